mod_down_counter: RTL
=====================

Name: mod_down_counter

Overview:
- Loadable modulo-N down-counter with terminal-count (borrow) pulse, periodic or one-shot operation, and a count-enable.
- Down-counting counterpart to the team's loadable modulo up-counter.
- Used as a programmable tick/timeout generator.
- Borrow output cascades into downstream counters or the enable input of pipeline stages.

Parameters:
- WIDTH, 4, width of count and load value.
- MODULE, 6, modulus; count range is 0..MODULE-1; legal 2..2**WIDTH.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- in  in  WIDTH  load value.
- load  in  1  synchronous load request; highest priority after reset.
- en  in  1  count enable; decrements only when 1.
- oneshot  in  1  mode select, sampled every cycle: 1 = one-shot, 0 = periodic.
- cnt  out  WIDTH  current count, registered.
- borrow  out  1  registered one-cycle pulse on terminal count (0 -> wrap or expire).
- running  out  1  registered; 1 in RUN state, 0 in IDLE.

Behaviour:
- Reset: reset=0 asynchronously forces cnt=0, borrow=0, running=0, state=IDLE. It overrides everything, including mid-count. The first clock edge after release behaves as normal IDLE.
- States: IDLE, RUN. running=1 exactly when state=RUN.
- All outputs update on the rising clock edge. There is no combinational path from inputs to outputs.
- Priority per edge: load > en. load is honoured in both states.
- Load:
  - cnt <= in if in < MODULE, else cnt <= MODULE-1 (clamped).
  - State -> RUN, borrow <= 0.
  - Load in the same cycle as a would-be terminal count suppresses that borrow.
- IDLE, no load: cnt holds, borrow <= 0. en is ignored. IDLE is left only via load.
- RUN, en=0, no load: cnt holds, borrow <= 0, state holds.
- RUN, en=1, cnt>0: cnt <= cnt-1, borrow <= 0.
- RUN, en=1, cnt==0, oneshot=0 (periodic): cnt <= MODULE-1, borrow <= 1, stay RUN.
- RUN, en=1, cnt==0, oneshot=1: cnt stays 0, borrow <= 1, state -> IDLE, running <= 0 on the same edge.
- Period: with en held high in periodic mode, borrow pulses once every MODULE cycles.
- Latency:
  - After load of value v with en=1, the first borrow is registered on the (v+1)-th enabled edge after the load edge.
  - Load of 0 with en=1 gives borrow on the next edge.
- borrow is never high for two consecutive cycles unless MODULE=1, which is illegal.
- Arithmetic:
  - Decrement is WIDTH-bit; no underflow is possible because 0 is handled explicitly.
  - MODULE-1 is truncated to WIDTH bits.
  - Clamp compare is unsigned.
- Switching oneshot mid-count: it takes effect at the next terminal count only. It does not change cnt.

Test Plan:
- Reset and hold: reset=0 then 1, en=1, no load, 10 cycles -> cnt=0, borrow=0, running=0 throughout. Assert reset=0 mid-count at cnt=3 -> cnt=0 and running=0 immediately, before any clock edge.
- Periodic: load in=5, en=1, oneshot=0, MODULE=6 -> cnt sequence 5,4,3,2,1,0,5,4,… Borrow is high only in the cycle where cnt=5 following 0, i.e. every 6 cycles. running stays 1.
- One-shot: load in=2, oneshot=1, en=1 -> cnt 2,1,0,0,… Borrow pulses once on the edge leaving 0. running drops to 0 on that same edge. Further en has no effect until the next load.
- Enable gating: load 4, en toggling 1,0,0,1,1,1,1 -> cnt 4,3,3,3,2,1,0,5. Borrow occurs only on the 0->5 step.
- Clamp and collision: load in=9 (MODULE=6) -> cnt=5. At cnt=0 with en=1, assert load in=3 -> cnt=3, borrow=0, running=1.
- Load of 0: load in=0, en=1, oneshot=0 -> next edge cnt=5, borrow=1.

Source files
------------

// File: rtl/mod_down_counter.sv
// mod_down_counter: loadable modulo-N down-counter with borrow pulse, periodic or one-shot.
module mod_down_counter #(
  parameter int WIDTH  = 4,
  parameter int MODULE = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             en,
  input  logic             oneshot,
  output logic [WIDTH-1:0] cnt,
  output logic             borrow,
  output logic             running
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULE - 1);
  state_t state;
  logic [WIDTH-1:0] load_val;
  logic zero, expire;
  // Unsigned compare widened by one bit so MODULE == 2**WIDTH never clamps.
  assign load_val = ({1'b0, in} < (WIDTH+1)'(MODULE)) ? in : MAX;
  assign zero = cnt == '0;
  assign expire = zero && oneshot;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      borrow  <= 1'b0;
      running <= 1'b0;
      state   <= IDLE;
    end else if (load) begin
      cnt     <= load_val;
      borrow  <= 1'b0;
      running <= 1'b1;
      state   <= RUN;
    end else if (state == RUN && en) begin
      cnt     <= zero ? (oneshot ? '0 : MAX) : cnt - 1'b1;
      borrow  <= zero;
      running <= !expire;
      state   <= expire ? IDLE : RUN;
    end else begin
      borrow  <= 1'b0;
    end
  end
endmodule
